alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, meaning 0 = round-robin grant and 1 = fixed priority to requester 0.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operation.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester n's operation is accepted this cycle.
REQ-006 SHALL have ports req0_alucode and req1_alucode, input, 6 bits each: operation code in the `ALU_* encoding from define.vh.
REQ-007 SHALL have ports req0_rs1, req0_rs2, req1_rs1 and req1_rs2, input, 32 bits each: operands.
REQ-008 SHALL have ports resp0_valid and resp1_valid, output, 1 bit each: a result is pending for requester n.
REQ-009 SHALL have ports resp0_ready and resp1_ready, input, 1 bit each: requester n consumes its result.
REQ-010 SHALL have ports resp_result (output, 32 bits) and resp_br_taken (output, 1 bit): shared result bus, meaningful only while a respN_valid is high.
REQ-011 SHALL have ports alu_alucode (output, 6 bits), alu_rs1 (output, 32 bits) and alu_rs2 (output, 32 bits): drive the shared combinational ALU.
REQ-012 SHALL have ports alu_result (input, 32 bits) and alu_br_taken (input, 1 bit): outputs returned by the shared ALU.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, EXEC and RESP.
REQ-015 In IDLE with at least one reqN_valid high, SHALL assert reqN_ready combinationally for exactly one granted requester, latch that requester's alucode, rs1, rs2 and id, and move to EXEC.
REQ-016 In IDLE with no requester valid, SHALL hold all ready and resp outputs low and stay in IDLE.
REQ-017 When both requesters are valid and PRIO_MODE=0, SHALL grant the requester other than the last granted one; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-018 When both requesters are valid and PRIO_MODE=1, SHALL always grant requester 0.
REQ-019 In EXEC, SHALL drive alu_* from the latched operands, capture alu_result and alu_br_taken into registers at the clock edge, and move to RESP unconditionally.
REQ-020 In IDLE and RESP, SHALL drive alu_alucode, alu_rs1 and alu_rs2 to 0.
REQ-021 In RESP, SHALL assert respN_valid only for the latched id and present the captured result and br_taken on the shared result bus.
REQ-022 In RESP, SHALL return to IDLE on the cycle respN_ready for the latched id is high, and otherwise hold all outputs stable.
REQ-023 The resp_ready of the non-granted requester SHALL be ignored.
REQ-024 While in EXEC or RESP, SHALL hold both reqN_ready low regardless of reqN_valid, applying backpressure.
REQ-025 Latency SHALL be: accepted at edge N, respN_valid high from cycle N+2; minimum issue interval 3 cycles.
REQ-026 SHALL pass alucode through unchecked, so undefined codes still complete with whatever the ALU returns.
REQ-027 SHALL update the last-granted pointer only on acceptance.
REQ-028 Once respN_valid is asserted, it SHALL NOT drop until the handshake completes.

Reset
REQ-029 Asserting rst_n low at any time, including mid-EXEC or mid-RESP, SHALL force IDLE, discard the in-flight operation and result, and set the last-granted pointer to 1.
REQ-030 During reset, all outputs SHALL be 0: ready, resp_valid, resp_result, resp_br_taken, alu_* and busy.
REQ-031 After rst_n deasserts, SHALL accept requests from the first rising clock edge.

Verification
REQ-032 Requester 0 issues `ALU_ADD with rs1=5, rs2=7 -> req0_ready high for 1 cycle; resp0_valid at +2 cycles with resp_result=12 and resp_br_taken=0.
REQ-033 With PRIO_MODE=0, both requesters hold valid continuously -> grants alternate 0,1,0,1 and each respN_valid appears only for its own id.
REQ-034 Requester 1 issues `ALU_BEQ with rs1=rs2=3 and resp1_ready is held low 4 cycles -> resp1_valid and resp_br_taken=1 stay stable, req0_ready stays 0 throughout, and release follows 1 cycle after resp1_ready rises.
REQ-035 With PRIO_MODE=1, both requesters valid for 3 operations -> requester 0 is granted all 3 and requester 1 is starved.
REQ-036 rst_n is pulsed low during EXEC -> busy=0 immediately, no resp_valid is ever produced for that operation, and the next request is accepted normally.
REQ-037 Requester 0 issues `ALU_SUB with rs1=0, rs2=1 -> resp_result=32'hFFFF_FFFF, demonstrating wrap-around from the shared ALU.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// It accepts one operation at a time, runs it through the ALU for one cycle,
// and then holds the result until the owning requester consumes it.
module alu_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [5:0]  req0_alucode,
    input  logic [5:0]  req1_alucode,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [31:0] resp_result,
    output logic        resp_br_taken,
    output logic [5:0]  alu_alucode,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    input  logic [31:0] alu_result,
    input  logic        alu_br_taken,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          id_q;
    logic          last_q;
    logic [CW-1:0] code_q;
    logic [DW-1:0] rs1_q;
    logic [DW-1:0] rs2_q;
    logic [DW-1:0] result_q;
    logic          br_q;
    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic          resp_done;

    // Grant select: requester 1 wins only alone, or on a round-robin tie after requester 0
    always_comb begin
        gnt1 = req1_valid && (!req0_valid || ((PRIO_MODE == 0) && !last_q));
        gnt0 = req0_valid && !gnt1;
    end

    // Next state, ready handshakes and ALU drive
    always_comb begin
        state_nxt   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_alucode = '0;
        alu_rs1     = '0;
        alu_rs2     = '0;
        accept      = 1'b0;
        resp_done   = id_q ? resp1_ready : resp0_ready;
        case (state)
            IDLE: begin
                req0_ready = gnt0 && rst_n;
                req1_ready = gnt1 && rst_n;
                accept     = gnt0 || gnt1;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_alucode = code_q;
                alu_rs1     = rs1_q;
                alu_rs2     = rs2_q;
                state_nxt   = RESP;
            end
            RESP: begin
                if (resp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response side is a pure function of the registered state
    always_comb begin
        resp0_valid   = (state == RESP) && !id_q;
        resp1_valid   = (state == RESP) && id_q;
        resp_result   = (state == RESP) ? result_q : '0;
        resp_br_taken = (state == RESP) && br_q;
        busy          = (state != IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch on acceptance, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            code_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            br_q     <= 1'b0;
        end else begin
            if (accept) begin
                id_q   <= gnt1;
                last_q <= gnt1;
                code_q <= gnt1 ? req1_alucode : req0_alucode;
                rs1_q  <= gnt1 ? req1_rs1 : req0_rs1;
                rs2_q  <= gnt1 ? req1_rs2 : req0_rs2;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                br_q     <= alu_br_taken;
            end
        end
    end

endmodule
